// File: rtl/mux_pkg.sv
// Shared constants for the result-bus channel mux/arbiter family.
package mux_pkg;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_SEL = 1'b1;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NCH   = 4;

endpackage : mux_pkg

// File: rtl/rr_grant.sv
// Round-robin grant: first requester at or after ptr_i, wrapping, via a
// double-width masked priority search.
module rr_grant #(
   parameter  int NCH  = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req_i,
   input  logic [SELW-1:0] ptr_i,
   output logic [NCH-1:0]  grant_o,
   output logic [SELW-1:0] idx_o
);

   logic [2*NCH-1:0] dreq;
   logic             found;

   assign dreq = {req_i, req_i};

   // NOTE: every output of a combinational block gets a default first,
   // otherwise paths that skip an assignment infer a latch.
   always_comb begin
      found   = 1'b0;
      idx_o   = '0;
      grant_o = '0;
      for (int j = 0; j < 2*NCH; j++) begin
         if (!found && dreq[j] && (j >= int'(ptr_i))) begin
            found = 1'b1;
            idx_o = (j >= NCH) ? SELW'(j - NCH) : SELW'(j);
         end
      end
      if (found) grant_o = NCH'(1) << idx_o;
   end

endmodule : rr_grant

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready merge onto one registered stream, with forced-select
// and round-robin modes.
module rr_mux_arb
   import mux_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NCH   = DEF_NCH,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_ch
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;
   logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

   logic [NCH-1:0]   rr_gnt;
   logic [SELW-1:0]  rr_idx;
   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  grant_idx;
   logic             load_en;
   logic             accept;

   rr_grant #(.NCH(NCH)) u_rr_grant (
      .req_i   (in_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (rr_gnt),
      .idx_o   (rr_idx)
   );

   // A select index beyond NCH-1 matches no channel, so it yields no grant.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      if (mode == MODE_SEL) begin
         for (int i = 0; i < NCH; i++) begin
            if ((sel == SELW'(i)) && in_valid[i]) begin
               grant[i]  = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end else begin
         grant     = rr_gnt;
         grant_idx = rr_idx;
      end
   end

   assign load_en  = !out_valid_q || out_ready;
   // Gated by rst_n: out_valid_q is 0 in reset, which would otherwise open load_en.
   assign in_ready = rst_n ? (grant & {NCH{load_en}}) : '0;
   assign accept   = |in_ready;

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (accept) begin
         out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
         out_valid_d = 1'b1;
         out_ch_d    = grant_idx;
         if (mode == MODE_RR)
            rr_ptr_d = (grant_idx == SELW'(NCH-1)) ? '0 : grant_idx + 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;

endmodule : rr_mux_arb

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: 4-channel main instance plus a 3-channel one.
module tb_rr_mux_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [31:0] d4;
   logic [3:0]  v4, r4;
   logic        m4;
   logic [1:0]  s4, ch4;
   logic [7:0]  od4;
   logic        ov4, ordy4;

   logic [23:0] d3;
   logic [2:0]  v3, r3;
   logic        m3;
   logic [1:0]  s3, ch3;
   logic [7:0]  od3;
   logic        ov3, ordy3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_mux_arb #(.WIDTH(8), .NCH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(r4),
      .mode(m4), .sel(s4), .out_data(od4), .out_valid(ov4), .out_ready(ordy4),
      .out_ch(ch4)
   );

   rr_mux_arb #(.WIDTH(8), .NCH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3),
      .mode(m3), .sel(s3), .out_data(od3), .out_valid(ov3), .out_ready(ordy3),
      .out_ch(ch3)
   );

   task automatic chk_out(input string name, input logic v, input logic [7:0] d,
                          input logic [1:0] c);
      checks++;
      if (ov4 !== v || od4 !== d || ch4 !== c) begin
         errors++;
         $display("FAIL %s: got valid=%b data=%h ch=%0d, want valid=%b data=%h ch=%0d",
                  name, ov4, od4, ch4, v, d, c);
      end
   endtask

   task automatic chk_rdy(input string name, input logic [3:0] exp);
      checks++;
      if (r4 !== exp) begin
         errors++;
         $display("FAIL %s: in_ready got %b want %b", name, r4, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      m4 = 1'b0; s4 = 2'd0; ordy4 = 1'b1; v4 = 4'b1111;
      d4 = {8'h44, 8'h77, 8'h22, 8'h11};
      #2;
      chk_out("reset_hold_out", 1'b0, 8'h00, 2'd0);
      chk_rdy("reset_hold_ready", 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      v4 = 4'b0100;
      #1;
      chk_rdy("post_reset_ready", 4'b0100);
      tick();
      chk_out("post_reset_accept", 1'b1, 8'h77, 2'd2);
      // rr_ptr is now 3; the mid-transfer reset must return it to 0.
      #2 rst_n = 1'b0;
      #1;
      chk_out("async_reset_out", 1'b0, 8'h00, 2'd0);
      chk_rdy("async_reset_ready", 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      v4 = 4'b1010;
      d4 = {8'hE3, 8'h00, 8'h9B, 8'h00};
      #1;
      chk_rdy("reset_ptr_zero_ready", 4'b0010);
      tick();
      chk_out("reset_first_accept", 1'b1, 8'h9B, 2'd1);
   endtask

   task automatic test_forced_sel;
      apply_reset();
      m4 = 1'b1; s4 = 2'd2; v4 = 4'b1111; ordy4 = 1'b1;
      d4 = {8'h44, 8'hA5, 8'h22, 8'h11};
      #1;
      chk_rdy("sel_ready", 4'b0100);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_out("sel_out", 1'b1, 8'hA5, 2'd2);
      end
      @(negedge clk);
      s4 = 2'd3;
      #1;
      chk_rdy("sel_change_ready", 4'b1000);
      chk_out("sel_change_held", 1'b1, 8'hA5, 2'd2);
      tick();
      chk_out("sel_change_out", 1'b1, 8'h44, 2'd3);
   endtask

   task automatic test_round_robin;
      logic [7:0] exp [4];
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
      apply_reset();
      m4 = 1'b0; v4 = 4'b1111; ordy4 = 1'b1;
      d4 = {8'h44, 8'h33, 8'h22, 8'h11};
      #1;
      chk_rdy("rr_first_ready", 4'b0001);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_out("rr_seq", 1'b1, exp[k % 4], 2'(k % 4));
      end
   endtask

   task automatic test_back_pressure;
      apply_reset();
      m4 = 1'b0; v4 = 4'b0001; ordy4 = 1'b1;
      d4 = {8'h00, 8'h00, 8'h00, 8'h3C};
      tick();
      chk_out("bp_load", 1'b1, 8'h3C, 2'd0);
      @(negedge clk);
      ordy4 = 1'b0; v4 = 4'b1111;
      d4 = {8'h4D, 8'h3D, 8'h5A, 8'hFF};
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_rdy("bp_stall_ready", 4'b0000);
         tick();
         chk_out("bp_stall_out", 1'b1, 8'h3C, 2'd0);
         @(negedge clk);
      end
      ordy4 = 1'b1;
      #1;
      chk_rdy("bp_release_ready", 4'b0010);
      tick();
      chk_out("bp_release_out", 1'b1, 8'h5A, 2'd1);
   endtask

   task automatic test_sparse;
      apply_reset();
      m4 = 1'b0; v4 = 4'b0001; ordy4 = 1'b1;
      d4 = {8'h00, 8'h00, 8'h00, 8'h01};
      tick();
      @(negedge clk);
      v4 = 4'b1001;
      d4 = {8'hD3, 8'h00, 8'h00, 8'hD0};
      #1;
      chk_rdy("sparse_ready_ch3", 4'b1000);
      tick();
      chk_out("sparse_ch3", 1'b1, 8'hD3, 2'd3);
      #1;
      chk_rdy("sparse_ready_ch0", 4'b0001);
      tick();
      chk_out("sparse_ch0", 1'b1, 8'hD0, 2'd0);
      @(negedge clk);
      v4 = 4'b0000;
      tick();
      chk_out("sparse_drain", 1'b0, 8'hD0, 2'd0);
   endtask

   task automatic test_non_pow2;
      m3 = 1'b1; s3 = 2'd3; v3 = 3'b111; ordy3 = 1'b1;
      d3 = {8'hC2, 8'hC1, 8'hC0};
      @(negedge clk);
      #1;
      checks++;
      if (r3 !== 3'b000) begin
         errors++;
         $display("FAIL np2_ready: got %b want 000", r3);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (ov3 !== 1'b0) begin
            errors++;
            $display("FAIL np2_no_valid: got %b want 0", ov3);
         end
      end
      @(negedge clk);
      s3 = 2'd1;
      tick();
      checks++;
      if (ov3 !== 1'b1 || od3 !== 8'hC1 || ch3 !== 2'd1) begin
         errors++;
         $display("FAIL np2_sel1: got valid=%b data=%h ch=%0d want 1 c1 1", ov3, od3, ch3);
      end
   endtask

   initial begin
      m3 = 1'b0; s3 = 2'd0; v3 = 3'b000; ordy3 = 1'b1; d3 = '0;
      test_reset();
      test_forced_sel();
      test_round_robin();
      test_back_pressure();
      test_sparse();
      test_non_pow2();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rr_mux_arb

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised successor to the team's byte-wide 4:1 select mux: N channels of W-bit data, each with a valid/ready handshake, merged onto one registered output stream.
- Two modes:
  - Forced select: the channel is chosen by a select input.
  - Round-robin: fair arbitration among valid channels.
- Sits between the datapath sources (register file, ALU, immediate, memory read) and the shared result bus.
- Replaces the combinational mux wherever back-pressure or fair sharing is needed.

Parameters:
- WIDTH, 8, data width per channel.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH), derived select width. Localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready. Combinational from grant and output state.
- mode  input  1  0 = round-robin, 1 = forced select.
- sel  input  SELW  channel index used when mode = 1.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_ch  output  SELW  index of the channel that supplied out_data (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_ch = 0, rr_ptr = 0.
  - Any held word is discarded.
  - in_ready is all-zero while rst_n is low.
- Load enable: load_en = !out_valid | out_ready.
- Grant, combinational, one-hot or zero:
  - mode = 1: grant[sel] = in_valid[sel]. If sel >= NCH (non-power-of-2 NCH), there is no grant.
  - mode = 0: the first i with in_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NCH.
  - No valid input: no grant.
- in_ready[i] = load_en & grant[i]. At most one bit is high.
- Transfer: in_valid[i] & in_ready[i] accepts the word at the clock edge:
  - out_data <= in_data[i]
  - out_ch <= i
  - out_valid <= 1
- Drain: out_valid & out_ready with no new grant gives out_valid <= 0. out_data and out_ch hold their last value.
- Latency and throughput:
  - Latency is 1 cycle from input acceptance to out_valid.
  - Sustained throughput is 1 word per cycle when out_ready stays high. Accept and drain happen on the same edge.
- Stall: while out_valid & !out_ready, out_data and out_ch are stable and every in_ready is 0.
- rr_ptr:
  - Updates only on an accepted transfer in mode 0: rr_ptr <= (i == NCH-1) ? 0 : i+1.
  - Unchanged in mode 1 and on idle cycles.
- Mode or sel changes:
  - Take effect in the combinational grant of the same cycle.
  - A word already held in the output register is unaffected.
- Inputs need not hold data stable while not granted. Only the accepted cycle's value is captured.

Decomposition:
- Shared package (mux_pkg):
  - MODE_RR = 1'b0, MODE_SEL = 1'b1.
  - Default WIDTH/NCH constants for the result bus.
- One natural sub-module: rr_grant. Combinational. Takes req[NCH] and ptr[SELW], returns one-hot grant[NCH] and its index. Implemented as a double-width masked priority search.
- rr_mux_arb holds the output register, rr_ptr and the mode selection.

Test Plan:
- Reset: assert rst_n low mid-transfer with out_valid = 1. Required: out_valid, out_data and out_ch drop to 0 immediately, asynchronously, and in_ready = 0000. After release, the first valid channel is accepted on the next edge.
- Forced select: mode = 1, sel = 2, in_valid = 1111, ch2 = 8'hA5, out_ready = 1. Required: only in_ready[2] is high. out_data = A5 and out_ch = 2 one cycle later, and every cycle thereafter.
- Round-robin fairness: mode = 0, all in_valid = 1, data ch0..3 = 11, 22, 33, 44, out_ready = 1. Required: the output sequence is 11, 22, 33, 44, 11, ... on consecutive cycles with out_ch 0, 1, 2, 3, 0, and the pointer wraps correctly.
- Back-pressure: out_ready = 0 for 3 cycles with out_valid = 1 holding 8'h3C. Required: out_data stays 3C, in_ready = 0000 and rr_ptr is unchanged. When out_ready returns to 1, the next grant is loaded on the same edge as the drain.
- Sparse requests with skip: mode = 0, rr_ptr = 1, in_valid = 1001. Required: ch3 is granted, then ch0. With in_valid = 0000, out_valid falls to 0 after the drain.
- Non-power-of-2: NCH = 3, mode = 1, sel = 3. Required: no grant, in_ready = 000, out_valid stays 0.
